alu_flag_unit: RTL and testbench
================================

# alu_flag_unit

Registered, parametrised status-flag unit for the ALU datapath, placed directly after the ALU output stage. It derives zero, sign, carry, overflow and parity flags from a WIDTH-bit result and registers them with a one-cycle valid handshake. It also keeps maskable sticky copies of each flag, raises a single-cycle interrupt pulse when a masked sticky flag first sets, and counts zero results in a saturating counter.

## Interface
Parameters:
- WIDTH, 16: result width in bits; legal values are 2 and above.
- CNT_W, 8: width of the zero-result counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  result, carry_in and overflow_in are valid this cycle.
- result  in  WIDTH  ALU result.
- carry_in  in  1  ALU carry/borrow out.
- overflow_in  in  1  ALU signed overflow.
- sticky_clr  in  FLAG_N  per-flag clear for the sticky register.
- irq_mask  in  FLAG_N  per-flag interrupt enable.
- cnt_clr  in  1  clears the zero counter.
- out_valid  out  1  flags holds a new sample.
- flags  out  FLAG_N  registered live flags {P,V,C,N,Z}.
- sticky  out  FLAG_N  accumulated flags.
- irq  out  1  single-cycle interrupt pulse.
- zero_cnt  out  CNT_W  saturating count of zero results.

## Operation
- Z = (result == 0); N = result[WIDTH-1]; C = carry_in; V = overflow_in; P = ^result, which is 1 for odd parity.
- When in_valid=1, flags is loaded with the new values. When in_valid=0, flags holds its previous value.
- out_valid is a registered copy of in_valid. There is no backpressure; a sample is accepted on every valid cycle.
- Sticky update, per bit i: sticky[i] <= (sticky[i] & ~sticky_clr[i]) | (in_valid & new_flag[i]).
  - Set wins over clear when both occur in the same cycle.
- irq pulses for exactly one cycle when any bit i satisfies irq_mask[i] & ~sticky[i] & next_sticky[i], i.e. on a 0→1 transition of a masked sticky bit.
  - Re-raising a flag whose sticky bit is already set does not pulse irq.
  - Changing irq_mask never produces a pulse retroactively for bits already set.
- zero_cnt increments when in_valid & Z and saturates at all-ones.
  - cnt_clr has priority: if cnt_clr=1, zero_cnt loads 1 when a zero result is accepted in the same cycle, otherwise 0.
- Reset: flags=0, sticky=0, out_valid=0, irq=0, zero_cnt=0.
  - A reset asserted mid-stream discards the sample presented in that cycle.

## Timing
- Latency from in_valid to out_valid/flags is 1 cycle. sticky, irq and zero_cnt reflect the same sample in that same cycle.
- Full throughput: one sample per cycle, back-to-back.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- The first sample after rst deasserts may be presented in the cycle immediately following.

## Structure
- Package alu_flag_pkg holds:
  - FLAG_N = 5;
  - index constants FLAG_Z=0, FLAG_N_IDX=1, FLAG_C=2, FLAG_V=3, FLAG_P=4;
  - typedef logic [FLAG_N-1:0] flags_t.
- Sub-module alu_flag_calc: purely combinational, parametrised by WIDTH, produces flags_t from result, carry_in and overflow_in. The top level contains only the registers, the sticky/irq logic and the counter.

## Test plan
- WIDTH=16, result=16'h0000 with in_valid → next cycle flags=5'b00001, out_valid=1, sticky=5'b00001, zero_cnt=1; irq=1 if irq_mask[0]=1.
- result=16'h8001, carry_in=1, overflow_in=1 → flags=5'b01110 (P=0 because two bits are set); then result=16'h8000 with carry_in=1 and irq_mask=5'b00100 → no irq (C sticky already set).
- sticky_clr=5'b00001 in the same cycle as a zero result → sticky[0] stays 1 (set wins); irq pulses only if the bit was 0 before.
- CNT_W=2, five consecutive zero results → zero_cnt goes 1,2,3,3,3; cnt_clr together with a zero result → zero_cnt=1.
- in_valid=0 for 3 cycles after a sample → flags held, out_valid=0, no irq; rst asserted during a valid sample → all outputs 0 next cycle and the sample is lost.
- WIDTH=8, result=8'hFF → flags N=1, P=0, Z=0; result=8'h07 → P=1.

Source files
------------

// File: rtl/alu_flag_pkg.sv
// rtl/alu_flag_pkg.sv - shared flag vector layout for the ALU status-flag unit
package alu_flag_pkg;

  localparam int FLAG_N = 5;

  localparam int FLAG_Z     = 0;
  localparam int FLAG_N_IDX = 1;
  localparam int FLAG_C     = 2;
  localparam int FLAG_V     = 3;
  localparam int FLAG_P     = 4;

  typedef logic [FLAG_N-1:0] flags_t;

endpackage

// File: rtl/alu_flag_calc.sv
// rtl/alu_flag_calc.sv - combinational derivation of {P,V,C,N,Z} from an ALU result
module alu_flag_calc
  import alu_flag_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] result,
  input  logic             carry_in,
  input  logic             overflow_in,
  output flags_t           flags
);

  always_comb begin
    flags              = '0;
    flags[FLAG_Z]      = (result == '0);
    flags[FLAG_N_IDX]  = result[WIDTH-1];
    flags[FLAG_C]      = carry_in;
    flags[FLAG_V]      = overflow_in;
    // odd parity reads as 1
    flags[FLAG_P]      = ^result;
  end

endmodule

// File: rtl/alu_flag_unit.sv
// rtl/alu_flag_unit.sv - registered live/sticky flags, masked sticky-set irq pulse,
// and a saturating zero-result counter
module alu_flag_unit
  import alu_flag_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  result,
  input  logic              carry_in,
  input  logic              overflow_in,
  input  flags_t            sticky_clr,
  input  flags_t            irq_mask,
  input  logic              cnt_clr,
  output logic              out_valid,
  output flags_t            flags,
  output flags_t            sticky,
  output logic              irq,
  output logic [CNT_W-1:0]  zero_cnt
);

  flags_t             new_flags;
  flags_t             flags_d, flags_q;
  flags_t             sticky_d, sticky_q;
  logic               irq_d, irq_q;
  logic               valid_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               zero_hit;

  alu_flag_calc #(.WIDTH(WIDTH)) u_calc (
    .result      (result),
    .carry_in    (carry_in),
    .overflow_in (overflow_in),
    .flags       (new_flags)
  );

  assign zero_hit = in_valid & new_flags[FLAG_Z];

  always_comb begin
    flags_d  = in_valid ? new_flags : flags_q;
    // a set in the same cycle as a clear wins
    sticky_d = (sticky_q & ~sticky_clr) | ({FLAG_N{in_valid}} & new_flags);
    irq_d    = |(irq_mask & ~sticky_q & sticky_d);

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = zero_hit ? CNT_W'(1) : '0;
    end else if (zero_hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q  <= '0;
      sticky_q <= '0;
      irq_q    <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      irq_q    <= irq_d;
      valid_q  <= in_valid;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign flags     = flags_q;
  assign sticky    = sticky_q;
  assign irq       = irq_q;
  assign zero_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// tb/tb_alu_flag_unit.sv - bench for alu_flag_unit: WIDTH=16/CNT_W=2 and WIDTH=8/CNT_W=8
module tb_alu_flag_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] res16;
  logic [7:0]  res8;
  logic        carry_in, overflow_in;
  logic [4:0]  sticky_clr, irq_mask;
  logic        cnt_clr;

  logic        ov16, ov8, irq16, irq8;
  logic [4:0]  fl16, fl8, st16, st8;
  logic [1:0]  zc16;
  logic [7:0]  zc8;

  int checks = 0;
  int errors = 0;

  logic [4:0] m_flags[2];
  logic [4:0] m_sticky[2];
  logic       m_irq[2];
  int         m_cnt[2];
  logic       m_valid;
  int         cmax[2] = '{3, 255};
  int         wid[2]  = '{16, 8};

  always #5 clk = ~clk;

  alu_flag_unit #(.WIDTH(16), .CNT_W(2)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .result(res16),
    .carry_in(carry_in), .overflow_in(overflow_in), .sticky_clr(sticky_clr),
    .irq_mask(irq_mask), .cnt_clr(cnt_clr), .out_valid(ov16), .flags(fl16),
    .sticky(st16), .irq(irq16), .zero_cnt(zc16)
  );

  alu_flag_unit #(.WIDTH(8), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .result(res8),
    .carry_in(carry_in), .overflow_in(overflow_in), .sticky_clr(sticky_clr),
    .irq_mask(irq_mask), .cnt_clr(cnt_clr), .out_valid(ov8), .flags(fl8),
    .sticky(st8), .irq(irq8), .zero_cnt(zc8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_flags(input int w, input logic [15:0] val,
                                           input logic c, input logic o);
    int ones;
    logic z, n, p;
    ones = $countones(val);
    z = (val == 16'd0);
    n = ((val >> (w - 1)) & 16'd1) != 16'd0;
    p = (ones % 2) == 1;
    return {p, o, c, n, z};
  endfunction

  task automatic step(input logic v, input logic [15:0] r16, input logic [7:0] r8,
                      input logic c, input logic o, input logic [4:0] sclr,
                      input logic [4:0] mask, input logic cclr, input logic r);
    logic [4:0] nf, old_s, new_s;
    rst = r; in_valid = v; res16 = r16; res8 = r8; carry_in = c; overflow_in = o;
    sticky_clr = sclr; irq_mask = mask; cnt_clr = cclr;
    m_valid = r ? 1'b0 : v;
    for (int d = 0; d < 2; d++) begin
      nf = ref_flags(wid[d], (d == 0) ? r16 : {8'h00, r8}, c, o);
      if (r) begin
        m_flags[d] = '0; m_sticky[d] = '0; m_irq[d] = 1'b0; m_cnt[d] = 0;
      end else begin
        if (v) m_flags[d] = nf;
        old_s = m_sticky[d];
        m_irq[d] = 1'b0;
        for (int i = 0; i < 5; i++) begin
          new_s[i] = (old_s[i] && !sclr[i]) || (v && nf[i]);
          if (mask[i] && !old_s[i] && new_s[i]) m_irq[d] = 1'b1;
        end
        m_sticky[d] = new_s;
        if (cclr) m_cnt[d] = (v && nf[0]) ? 1 : 0;
        else if (v && nf[0] && m_cnt[d] < cmax[d]) m_cnt[d] = m_cnt[d] + 1;
      end
    end
    @(posedge clk);
    #1;
    chk("valid16", 32'(ov16), 32'(m_valid));
    chk("flags16", 32'(fl16), 32'(m_flags[0]));
    chk("sticky16", 32'(st16), 32'(m_sticky[0]));
    chk("irq16", 32'(irq16), 32'(m_irq[0]));
    chk("cnt16", 32'(zc16), 32'(m_cnt[0]));
    chk("valid8", 32'(ov8), 32'(m_valid));
    chk("flags8", 32'(fl8), 32'(m_flags[1]));
    chk("sticky8", 32'(st8), 32'(m_sticky[1]));
    chk("irq8", 32'(irq8), 32'(m_irq[1]));
    chk("cnt8", 32'(zc8), 32'(m_cnt[1]));
  endtask

  initial begin
    // reset state
    step(0, 16'h0, 8'h0, 0, 0, 5'h0, 5'h0, 0, 1);
    step(0, 16'h0, 8'h0, 0, 0, 5'h0, 5'h0, 0, 1);
    chk("rst_flags", 32'(fl16), 32'h0);
    chk("rst_cnt", 32'(zc16), 32'h0);

    // first zero result right after reset
    step(1, 16'h0000, 8'h00, 0, 0, 5'h0, 5'b00001, 0, 0);
    chk("zero_flags", 32'(fl16), 32'b00001);
    chk("zero_irq", 32'(irq16), 32'h1);
    chk("zero_cnt", 32'(zc16), 32'h1);

    step(1, 16'h8001, 8'h81, 1, 1, 5'h0, 5'h0, 0, 0);
    chk("p_even_flags", 32'(fl16), 32'b01110);
    step(1, 16'h8000, 8'h80, 1, 0, 5'h0, 5'b00100, 0, 0);
    chk("c_rearm_irq", 32'(irq16), 32'h0);

    // set wins over clear
    step(1, 16'h0000, 8'h00, 0, 0, 5'b00001, 5'b00001, 0, 0);
    chk("set_wins", 32'(st16[0]), 32'h1);
    chk("set_wins_irq", 32'(irq16), 32'h0);

    // counter clear with zero, then saturation of the 2-bit counter
    step(1, 16'h0000, 8'h00, 0, 0, 5'h0, 5'h0, 1, 0);
    chk("clr_zero_cnt", 32'(zc16), 32'h1);
    for (int k = 0; k < 4; k++) step(1, 16'h0000, 8'h00, 0, 0, 5'h0, 5'h0, 0, 0);
    chk("sat_cnt", 32'(zc16), 32'h3);

    // idle cycles hold flags
    for (int k = 0; k < 3; k++) step(0, 16'h1234, 8'h34, 1, 1, 5'h0, 5'h1f, 0, 0);
    chk("idle_valid", 32'(ov16), 32'h0);

    // reset during a valid sample drops it
    step(1, 16'hffff, 8'hff, 1, 1, 5'h0, 5'h1f, 0, 1);
    chk("rst_mid_sticky", 32'(st16), 32'h0);

    step(1, 16'h00ff, 8'hff, 0, 0, 5'h0, 5'h0, 0, 0);
    chk("w8_ff", 32'(fl8), 32'b00010);
    step(1, 16'h0007, 8'h07, 0, 0, 5'h0, 5'h0, 0, 0);
    chk("w8_07", 32'(fl8), 32'b10000);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic [15:0] r16;
      logic [7:0]  r8;
      r16 = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      r8  = ($urandom_range(0, 3) == 0) ? 8'h0 : 8'($urandom);
      step(($urandom_range(0, 9) < 7), r16, r8, 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h0, 5'($urandom),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
